interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 Parameter: EXT_SYNC, default 1, 1 = two-flop synchronizer on ext_irq, 0 = ext_irq used directly.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-high, so rst_n=1 resets on the clock edge.
REQ-005 ext_irq  input  1  external interrupt request, asynchronous, rising-edge sensitive.
REQ-006 timer_irq  input  1  machine timer request, synchronous level.
REQ-007 soft_irq  input  1  machine software request, synchronous level.
REQ-008 csr_meie / csr_mtie / csr_msie  input  1 each  per-source enables from the CSR block.
REQ-009 csr_rmie  input  1  mstatus.MIE global enable.
REQ-010 cmd_mret_ex  input  1  mret in EX stage.
REQ-011 cmd_ecall_ex  input  1  ecall in EX stage.
REQ-012 stall  input  1  pipeline stall; no interrupt is taken while 1.
REQ-013 g_interrupt  output  1  one-cycle interrupt-take pulse to the CSR block.
REQ-014 g_interrupt_priv  output  2  target privilege of the taken interrupt; always 2'b11.
REQ-015 g_current_priv  output  2  current hart privilege.
REQ-016 int_cause  output  5  cause code of the last taken interrupt: 11 ext, 3 soft, 7 timer.
REQ-017 int_busy  output  1  1 while in HANDLER state.

Function
REQ-018 The ext path shall, when EXT_SYNC=1, pass ext_irq through two flops, then detect a rising edge of the synchronized signal.
REQ-019 A detected ext edge shall set ext_pend; ext_pend shall clear only when an ext interrupt is taken, and a new edge in the same cycle as the clear shall keep ext_pend=1.
REQ-020 timer and soft requests shall be level and not latched; pend_t=timer_irq, pend_s=soft_irq.
REQ-021 Eligibility: eligible = (ext_pend&csr_meie) | (pend_s&csr_msie) | (pend_t&csr_mtie).
REQ-022 Priority among eligible sources: ext > soft > timer, fixed.
REQ-023 FSM states are IDLE, TAKE, HANDLER and RECOVER.
REQ-024 IDLE->TAKE: eligible & csr_rmie & ~stall & ~cmd_ecall_ex & ~cmd_mret_ex, sampled at cycle N; winning cause is captured into int_cause at the same edge.
REQ-025 TAKE: g_interrupt=1 for exactly this one cycle (cycle N+1); the ext_pend clear happens at the end of TAKE if cause=11; next state HANDLER unconditionally.
REQ-026 HANDLER: g_interrupt=0; new requests shall be ignored but ext edges still latch into ext_pend.
REQ-027 HANDLER->RECOVER on cmd_mret_ex & ~stall; cmd_mret_ex while stall=1 shall be ignored.
REQ-028 RECOVER: one mandatory idle cycle, then IDLE, so there is a minimum of 2 cycles from mret to the next g_interrupt pulse.
REQ-029 g_interrupt shall be driven from a flop (state==TAKE decoded registered), with no combinational path from inputs.
REQ-030 g_current_priv shall be 2'b11 in all states (M-mode only); it is registered and loaded with 2'b11 on TAKE and on mret.
REQ-031 g_interrupt_priv shall be constant 2'b11.
REQ-032 Disabling an enable or csr_rmie while in TAKE shall not cancel the pulse already scheduled.
REQ-033 cmd_ecall_ex and an eligible interrupt in the same IDLE cycle: the ecall wins, and the interrupt is re-evaluated the next cycle.
REQ-034 int_cause shall hold its value until the next TAKE.

Reset
REQ-035 On rst_n=1 at a clock edge: state=IDLE, g_interrupt=0, int_cause=0, int_busy=0, ext_pend=0, synchronizer flops=0, edge-detect history=0, g_current_priv=2'b11.
REQ-036 Reset asserted mid-TAKE or mid-HANDLER shall abort to IDLE with no further pulse; outputs take reset values on the next cycle.
REQ-037 Outputs shall be valid on the first cycle after reset deasserts.

Verification
REQ-038 Scenario 1: csr_rmie=1, csr_mtie=1, timer_irq=1 at cycle 10, stall=0 -> g_interrupt=1 in cycle 11 only, int_cause=7, int_busy=1 from cycle 12.
REQ-039 Scenario 2: ext edge, timer and soft all eligible simultaneously -> int_cause=11; after mret and RECOVER, soft is taken next with int_cause=3.
REQ-040 Scenario 3: request eligible while stall=1 for 5 cycles -> no pulse; pulse occurs 1 cycle after stall drops.
REQ-041 Scenario 4: ext_irq pulses during HANDLER -> ext_pend=1; after mret at cycle M, g_interrupt=1 at cycle M+3 with int_cause=11.
REQ-042 Scenario 5: cmd_ecall_ex=1 in the same cycle as an eligible soft_irq -> no pulse that cycle; pulse one cycle later.
REQ-043 Scenario 6: rst_n=1 during HANDLER with ext_pend=1 -> next cycle state IDLE, ext_pend=0, int_cause=0, and no pulse with timer/soft low.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// Machine-mode interrupt controller: synchronizes and edge-detects the external
// request, arbitrates ext > soft > timer and issues a single-cycle take pulse
// to the CSR block.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an eligible, globally enabled request
// TAKE    | g_interrupt pulse cycle, cause already captured
// HANDLER | trap handler running; requests ignored until mret
// RECOVER | single dead cycle after mret before re-arbitration
module interrupt_ctrl #(
    parameter int EXT_SYNC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ext_irq,
    input  logic       timer_irq,
    input  logic       soft_irq,
    input  logic       csr_meie,
    input  logic       csr_mtie,
    input  logic       csr_msie,
    input  logic       csr_rmie,
    input  logic       cmd_mret_ex,
    input  logic       cmd_ecall_ex,
    input  logic       stall,
    output logic       g_interrupt,
    output logic [1:0] g_interrupt_priv,
    output logic [1:0] g_current_priv,
    output logic [4:0] int_cause,
    output logic       int_busy
);

    localparam logic [4:0] CAUSE_EXT   = 5'd11;
    localparam logic [4:0] CAUSE_SOFT  = 5'd3;
    localparam logic [4:0] CAUSE_TIMER = 5'd7;
    localparam logic [1:0] PRIV_M      = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t     state;
    logic       ext_s;
    logic       ext_prev;
    logic       ext_edge;
    logic       ext_pend;
    logic       ext_clr;
    logic       elig_e;
    logic       elig_s;
    logic       elig_t;
    logic       take_ok;
    logic [4:0] win_cause;

    generate
        if (EXT_SYNC != 0) begin : g_sync
            logic sync1;
            logic sync2;

            // Two-flop synchronizer for the asynchronous external request.
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    sync1 <= 1'b0;
                    sync2 <= 1'b0;
                end else begin
                    sync1 <= ext_irq;
                    sync2 <= sync1;
                end
            end

            assign ext_s = sync2;
        end else begin : g_nosync
            assign ext_s = ext_irq;
        end
    endgenerate

    assign ext_edge = ext_s & ~ext_prev;
    assign ext_clr  = (state == TAKE) && (int_cause == CAUSE_EXT);

    // Edge history and sticky external pending bit; a new edge beats the clear.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ext_prev <= 1'b0;
            ext_pend <= 1'b0;
        end else begin
            ext_prev <= ext_s;
            ext_pend <= (ext_pend & ~ext_clr) | ext_edge;
        end
    end

    assign elig_e  = ext_pend & csr_meie;
    assign elig_s  = soft_irq & csr_msie;
    assign elig_t  = timer_irq & csr_mtie;
    assign take_ok = (elig_e | elig_s | elig_t) & csr_rmie & ~stall
                     & ~cmd_ecall_ex & ~cmd_mret_ex;

    // Fixed priority arbitration of the eligible sources.
    always_comb begin
        win_cause = CAUSE_TIMER;
        if (elig_e)
            win_cause = CAUSE_EXT;
        else if (elig_s)
            win_cause = CAUSE_SOFT;
    end

    assign g_interrupt_priv = PRIV_M;

    // Interrupt sequencing FSM with registered pulse, cause, busy and privilege.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state          <= IDLE;
            g_interrupt    <= 1'b0;
            int_cause      <= 5'd0;
            int_busy       <= 1'b0;
            g_current_priv <= PRIV_M;
        end else begin
            case (state)
                IDLE: begin
                    if (take_ok) begin
                        state          <= TAKE;
                        g_interrupt    <= 1'b1;
                        int_cause      <= win_cause;
                        g_current_priv <= PRIV_M;
                    end
                end
                TAKE: begin
                    state       <= HANDLER;
                    g_interrupt <= 1'b0;
                    int_busy    <= 1'b1;
                end
                HANDLER: begin
                    if (cmd_mret_ex && !stall) begin
                        state          <= RECOVER;
                        int_busy       <= 1'b0;
                        g_current_priv <= PRIV_M;
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    g_interrupt <= 1'b0;
                    int_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed testbench for interrupt_ctrl. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, i.e. they show the value held
// during the cycle that just began.
module tb_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ext_irq, timer_irq, soft_irq;
    logic       csr_meie, csr_mtie, csr_msie, csr_rmie;
    logic       cmd_mret_ex, cmd_ecall_ex, stall;
    logic       g_interrupt;
    logic [1:0] g_interrupt_priv, g_current_priv;
    logic [4:0] int_cause;
    logic       int_busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    interrupt_ctrl #(.EXT_SYNC(1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ext_irq          (ext_irq),
        .timer_irq        (timer_irq),
        .soft_irq         (soft_irq),
        .csr_meie         (csr_meie),
        .csr_mtie         (csr_mtie),
        .csr_msie         (csr_msie),
        .csr_rmie         (csr_rmie),
        .cmd_mret_ex      (cmd_mret_ex),
        .cmd_ecall_ex     (cmd_ecall_ex),
        .stall            (stall),
        .g_interrupt      (g_interrupt),
        .g_interrupt_priv (g_interrupt_priv),
        .g_current_priv   (g_current_priv),
        .int_cause        (int_cause),
        .int_busy         (int_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop requests, retire the handler and let RECOVER pass.
    task automatic finish_handler();
        timer_irq = 1'b0;
        soft_irq  = 1'b0;
        cmd_mret_ex = 1'b1;
        tick();
        cmd_mret_ex = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        ext_irq = 0; timer_irq = 0; soft_irq = 0;
        csr_meie = 0; csr_mtie = 0; csr_msie = 0; csr_rmie = 0;
        cmd_mret_ex = 0; cmd_ecall_ex = 0; stall = 0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL reset_pulse got=%0b exp=0", g_interrupt); else pass_cnt++;
        chk_cnt++; if (int_cause !== 5'd0) $display("FAIL reset_cause got=%0d exp=0", int_cause); else pass_cnt++;
        chk_cnt++; if (int_busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", int_busy); else pass_cnt++;
        chk_cnt++; if (g_current_priv !== 2'b11) $display("FAIL reset_priv got=%0b exp=11", g_current_priv); else pass_cnt++;
        chk_cnt++; if (g_interrupt_priv !== 2'b11) $display("FAIL reset_ipriv got=%0b exp=11", g_interrupt_priv); else pass_cnt++;
    endtask

    task automatic test_timer();
        csr_rmie = 1; csr_mtie = 1;
        tick();
        timer_irq = 1;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b1) $display("FAIL timer_pulse got=%0b exp=1", g_interrupt); else pass_cnt++;
        chk_cnt++; if (int_cause !== 5'd7) $display("FAIL timer_cause got=%0d exp=7", int_cause); else pass_cnt++;
        chk_cnt++; if (int_busy !== 1'b0) $display("FAIL timer_busy_take got=%0b exp=0", int_busy); else pass_cnt++;
        // Pulling enables during TAKE must not cancel the take.
        csr_rmie = 0; csr_mtie = 0;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL timer_pulse_end got=%0b exp=0", g_interrupt); else pass_cnt++;
        chk_cnt++; if (int_busy !== 1'b1) $display("FAIL timer_busy got=%0b exp=1", int_busy); else pass_cnt++;
        csr_rmie = 1; csr_mtie = 1;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL timer_handler_ignore got=%0b exp=0", g_interrupt); else pass_cnt++;
        chk_cnt++; if (g_current_priv !== 2'b11) $display("FAIL timer_priv got=%0b exp=11", g_current_priv); else pass_cnt++;
        finish_handler();
        chk_cnt++; if (int_busy !== 1'b0) $display("FAIL timer_busy_clr got=%0b exp=0", int_busy); else pass_cnt++;
        chk_cnt++; if (int_cause !== 5'd7) $display("FAIL timer_cause_hold got=%0d exp=7", int_cause); else pass_cnt++;
    endtask

    task automatic test_priority();
        csr_rmie = 0; csr_meie = 1; csr_msie = 1; csr_mtie = 1;
        soft_irq = 1; timer_irq = 1;
        ext_irq = 1;
        tick();
        ext_irq = 0;
        repeat (5) tick();
        csr_rmie = 1;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b1) $display("FAIL prio_pulse got=%0b exp=1", g_interrupt); else pass_cnt++;
        chk_cnt++; if (int_cause !== 5'd11) $display("FAIL prio_cause_ext got=%0d exp=11", int_cause); else pass_cnt++;
        tick();
        tick();
        cmd_mret_ex = 1;
        tick();
        cmd_mret_ex = 0;
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL prio_recover got=%0b exp=0", g_interrupt); else pass_cnt++;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL prio_idle got=%0b exp=0", g_interrupt); else pass_cnt++;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b1) $display("FAIL prio_second_pulse got=%0b exp=1", g_interrupt); else pass_cnt++;
        chk_cnt++; if (int_cause !== 5'd3) $display("FAIL prio_cause_soft got=%0d exp=3", int_cause); else pass_cnt++;
        tick();
        finish_handler();
        csr_mtie = 0;
    endtask

    task automatic test_stall();
        int early = 0;
        stall = 1; soft_irq = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (g_interrupt !== 1'b0) early++;
        end
        chk_cnt++; if (early !== 0) $display("FAIL stall_block got=%0d pulses exp=0", early); else pass_cnt++;
        stall = 0;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b1) $display("FAIL stall_release got=%0b exp=1", g_interrupt); else pass_cnt++;
        soft_irq = 0;
        tick();
        // mret under stall must be ignored.
        stall = 1; cmd_mret_ex = 1;
        tick();
        tick();
        chk_cnt++; if (int_busy !== 1'b1) $display("FAIL stall_mret_ignored got=%0b exp=1", int_busy); else pass_cnt++;
        stall = 0; cmd_mret_ex = 0;
    endtask

    task automatic test_ext_in_handler();
        ext_irq = 1;
        tick();
        ext_irq = 0;
        repeat (5) tick();
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL exth_nopulse got=%0b exp=0", g_interrupt); else pass_cnt++;
        cmd_mret_ex = 1;
        tick();
        cmd_mret_ex = 0;
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL exth_m1 got=%0b exp=0", g_interrupt); else pass_cnt++;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL exth_m2 got=%0b exp=0", g_interrupt); else pass_cnt++;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b1) $display("FAIL exth_m3 got=%0b exp=1", g_interrupt); else pass_cnt++;
        chk_cnt++; if (int_cause !== 5'd11) $display("FAIL exth_cause got=%0d exp=11", int_cause); else pass_cnt++;
        tick();
        finish_handler();
    endtask

    task automatic test_ecall();
        cmd_ecall_ex = 1; soft_irq = 1;
        tick();
        cmd_ecall_ex = 0;
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL ecall_block got=%0b exp=0", g_interrupt); else pass_cnt++;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b1) $display("FAIL ecall_retry got=%0b exp=1", g_interrupt); else pass_cnt++;
        chk_cnt++; if (int_cause !== 5'd3) $display("FAIL ecall_cause got=%0d exp=3", int_cause); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_handler();
        int stray = 0;
        soft_irq = 0;
        ext_irq = 1;
        tick();
        ext_irq = 0;
        repeat (5) tick();
        rst_n = 1;
        tick();
        rst_n = 0;
        chk_cnt++; if (int_busy !== 1'b0) $display("FAIL rsth_busy got=%0b exp=0", int_busy); else pass_cnt++;
        chk_cnt++; if (int_cause !== 5'd0) $display("FAIL rsth_cause got=%0d exp=0", int_cause); else pass_cnt++;
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL rsth_pulse got=%0b exp=0", g_interrupt); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (g_interrupt !== 1'b0) stray++;
        end
        chk_cnt++; if (stray !== 0) $display("FAIL rsth_pend_cleared got=%0d pulses exp=0", stray); else pass_cnt++;
    endtask

    task automatic test_reset_take();
        int stray = 0;
        csr_mtie = 1; timer_irq = 1;
        tick();
        chk_cnt++; if (g_interrupt !== 1'b1) $display("FAIL rstt_pulse got=%0b exp=1", g_interrupt); else pass_cnt++;
        rst_n = 1; timer_irq = 0;
        tick();
        rst_n = 0;
        chk_cnt++; if (g_interrupt !== 1'b0) $display("FAIL rstt_abort got=%0b exp=0", g_interrupt); else pass_cnt++;
        chk_cnt++; if (int_cause !== 5'd0) $display("FAIL rstt_cause got=%0d exp=0", int_cause); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (g_interrupt !== 1'b0 || int_busy !== 1'b0) stray++;
        end
        chk_cnt++; if (stray !== 0) $display("FAIL rstt_quiet got=%0d bad cycles exp=0", stray); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_timer();
        test_priority();
        test_stall();
        test_ext_in_handler();
        test_ecall();
        test_reset_handler();
        test_reset_take();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
